// File: rtl/ram_explorer_pkg.sv
// Shared definitions for the RAM explorer: mode codes, FSM states and a
// small helper that decides which operations mark the display as "written".
package ram_explorer_pkg;

   localparam logic [1:0] MODE_READ  = 2'b00;
   localparam logic [1:0] MODE_WRITE = 2'b01;
   localparam logic [1:0] MODE_FILL  = 2'b10;
   localparam logic [1:0] MODE_SCAN  = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD,
      ST_RD_Q,
      ST_WR,
      ST_FILL,
      ST_SCAN_RD,
      ST_SCAN_HOLD
   } state_e;

   // WRITE and FILL leave the display in "written" (E) state.
   function automatic logic is_write_mode(input logic [1:0] m);
      return (m == MODE_WRITE) || (m == MODE_FILL);
   endfunction

endpackage

// File: rtl/ram_explorer_sync_ram.sv
// Single-port synchronous RAM with one-cycle registered read.
// A read during a write returns the previous contents of that word.
module sync_ram #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 8
) (
   input  logic              clock,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [2**ADDR_W];
   logic [DATA_W-1:0] rdata_q;

   // Write port and registered read port share one address.
   // NOTE: the array has no reset; resetting a memory costs a port per word
   // and prevents mapping onto block RAM, so contents survive resetn.
   always_ff @(posedge clock) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      rdata_q <= mem[addr];
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/ram_explorer.sv
// RAM explorer: a push-button driven controller around a small synchronous
// RAM. One "go" press performs a read, a write (with read-back), a fill of
// the whole RAM with an incrementing pattern, or starts an auto-scan.
module ram_explorer
   import ram_explorer_pkg::*;
#(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 8,
   parameter int DWELL  = 50000000
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              go,
   input  logic [1:0]        mode,
   input  logic [ADDR_W-1:0] addr_in,
   input  logic [DATA_W-1:0] data_in,
   output logic [ADDR_W-1:0] cur_addr,
   output logic [DATA_W-1:0] q,
   output logic              wr_flag,
   output logic              busy,
   output logic              done
);

   localparam int CNT_W = $clog2(DWELL + 1);
   localparam logic [CNT_W-1:0]  DWELL_LAST = CNT_W'(DWELL - 1);
   localparam logic [ADDR_W-1:0] IDX_LAST   = '1;

   // Button synchroniser and edge-detect history.
   logic s1_q, s2_q, s3_q;
   logic start;

   state_e            state_q,    state_d;
   logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
   logic [DATA_W-1:0] dout_q,     dout_d;
   logic              wr_flag_q,  wr_flag_d;
   logic              busy_q,     busy_d;
   logic              done_q,     done_d;
   logic [CNT_W-1:0]  cnt_q,      cnt_d;
   logic [ADDR_W-1:0] idx_q,      idx_d;
   logic [ADDR_W-1:0] base_q,     base_d;
   logic [DATA_W-1:0] seed_q,     seed_d;

   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;

   logic [ADDR_W-1:0] fill_addr;
   logic [DATA_W-1:0] fill_data;
   logic              scan_stop;

   assign start     = s2_q & ~s3_q;
   assign fill_addr = base_q + idx_q;
   assign fill_data = seed_q + DATA_W'(idx_q);
   assign scan_stop = start || (mode != MODE_SCAN);

   sync_ram #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_ram (
      .clock (clock),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

   // Next-state, RAM port and output-register logic for the control FSM.
   always_comb begin
      // NOTE: every signal gets a default here so that no path through the
      // case statement leaves one unassigned and infers a latch.
      state_d    = state_q;
      cur_addr_d = cur_addr_q;
      dout_d     = dout_q;
      wr_flag_d  = wr_flag_q;
      done_d     = 1'b0;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      base_d     = base_q;
      seed_d     = seed_q;
      ram_we     = 1'b0;
      ram_addr   = cur_addr_q;
      ram_wdata  = seed_q;

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               // Switches are captured here; later changes do not disturb
               // a running WRITE or FILL.
               cur_addr_d = addr_in;
               wr_flag_d  = is_write_mode(mode);
               base_d     = addr_in;
               seed_d     = data_in;
               idx_d      = '0;
               cnt_d      = '0;
               unique case (mode)
                  MODE_READ:  state_d = ST_RD;
                  MODE_WRITE: state_d = ST_WR;
                  MODE_FILL:  state_d = ST_FILL;
                  default:    state_d = ST_SCAN_RD;
               endcase
            end
         end

         ST_RD: begin
            state_d = ST_RD_Q;
         end

         ST_RD_Q: begin
            dout_d  = ram_rdata;
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end

         ST_WR: begin
            // Write, then reuse the read path so q shows the stored word.
            ram_we  = 1'b1;
            state_d = ST_RD;
         end

         ST_FILL: begin
            ram_we     = 1'b1;
            ram_addr   = fill_addr;
            ram_wdata  = fill_data;
            cur_addr_d = fill_addr;
            dout_d     = fill_data;
            if (idx_q == IDX_LAST) begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end

         ST_SCAN_RD: begin
            // cnt_q doubles as the read phase: 0 = address issued,
            // 1 = registered RAM output valid.
            if (scan_stop) begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end else if (cnt_q == '0) begin
               cnt_d = CNT_W'(1);
            end else begin
               dout_d  = ram_rdata;
               cnt_d   = '0;
               state_d = ST_SCAN_HOLD;
            end
         end

         ST_SCAN_HOLD: begin
            // Stop wins over an address advance in the same cycle.
            if (scan_stop) begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end else if (cnt_q == DWELL_LAST) begin
               cur_addr_d = cur_addr_q + 1'b1;
               cnt_d      = '0;
               state_d    = ST_SCAN_RD;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   // State, output and synchroniser registers; reset aborts any operation.
   always_ff @(posedge clock or negedge resetn) begin
      // NOTE: non-blocking assignments make every flop sample the values from
      // before the edge, so the s1->s2->s3 chain shifts one stage per clock.
      if (!resetn) begin
         s1_q       <= 1'b0;
         s2_q       <= 1'b0;
         s3_q       <= 1'b0;
         state_q    <= ST_IDLE;
         cur_addr_q <= '0;
         dout_q     <= '0;
         wr_flag_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         cnt_q      <= '0;
         idx_q      <= '0;
         base_q     <= '0;
         seed_q     <= '0;
      end else begin
         s1_q       <= go;
         s2_q       <= s1_q;
         s3_q       <= s2_q;
         state_q    <= state_d;
         cur_addr_q <= cur_addr_d;
         dout_q     <= dout_d;
         wr_flag_q  <= wr_flag_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         base_q     <= base_d;
         seed_q     <= seed_d;
      end
   end

   assign cur_addr = cur_addr_q;
   assign q        = dout_q;
   assign wr_flag  = wr_flag_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_ram_explorer.sv
// Self-checking bench for ram_explorer: directed scenarios plus randomized
// read/write traffic checked against an array model of the RAM.
module tb_ram_explorer;

   localparam int ADDR_W = 5;
   localparam int DATA_W = 8;
   localparam int DEPTH  = 32;
   localparam int DWELL  = 4;

   localparam logic [1:0] M_READ  = 2'b00;
   localparam logic [1:0] M_WRITE = 2'b01;
   localparam logic [1:0] M_FILL  = 2'b10;
   localparam logic [1:0] M_SCAN  = 2'b11;

   logic              clock;
   logic              resetn;
   logic              go;
   logic [1:0]        mode;
   logic [ADDR_W-1:0] addr_in;
   logic [DATA_W-1:0] data_in;
   logic [ADDR_W-1:0] cur_addr;
   logic [DATA_W-1:0] q;
   logic              wr_flag;
   logic              busy;
   logic              done;

   int n_checks = 0;
   int n_errors = 0;

   // Reference image of the RAM contents.
   logic [DATA_W-1:0] mem_m [DEPTH];

   ram_explorer #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .DWELL  (DWELL)
   ) dut (
      .clock    (clock),
      .resetn   (resetn),
      .go       (go),
      .mode     (mode),
      .addr_in  (addr_in),
      .data_in  (data_in),
      .cur_addr (cur_addr),
      .q        (q),
      .wr_flag  (wr_flag),
      .busy     (busy),
      .done     (done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One go press with the given switches; waits for busy to rise and fall.
   // With disturb set, the switches change and go is pressed again mid-run.
   task automatic run_op(input logic [1:0] m, input logic [4:0] a, input logic [7:0] d,
                         input bit disturb, output int n_done, output int n_busy,
                         output bit done_idle);
      bit seen;
      bit ok;
      @(negedge clock);
      mode = m; addr_in = a; data_in = d; go = 1'b1;
      n_done = 0; n_busy = 0; done_idle = 1'b0; seen = 1'b0; ok = 1'b0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clock);
         if (c == 2) go = 1'b0;
         if (disturb && c == 5) begin
            addr_in = ~a; data_in = ~d; mode = M_READ;
         end
         if (disturb && c == 10) go = 1'b1;
         if (disturb && c == 14) go = 1'b0;
         if (busy) begin
            n_busy++;
            seen = 1'b1;
         end
         if (done) begin
            n_done++;
            done_idle = !busy;
         end
         if (seen && !busy) begin
            ok = 1'b1;
            break;
         end
      end
      go = 1'b0;
      check("op_complete", ok, 1'b1);
      repeat (3) @(negedge clock);
   endtask

   task automatic do_write(input logic [4:0] a, input logic [7:0] d);
      int nd, nb; bit di;
      run_op(M_WRITE, a, d, 1'b0, nd, nb, di);
      mem_m[a] = d;
      check("wr_done", nd, 1);
      check("wr_done_idle", di, 1'b1);
      check("wr_q", q, d);
      check("wr_flag_w", wr_flag, 1'b1);
      check("wr_addr", cur_addr, a);
   endtask

   task automatic do_read(input string tag, input logic [4:0] a);
      int nd, nb; bit di;
      run_op(M_READ, a, $urandom, 1'b0, nd, nb, di);
      check({tag, "_done"}, nd, 1);
      check({tag, "_q"}, q, mem_m[a]);
      check({tag, "_flag"}, wr_flag, 1'b0);
      check({tag, "_addr"}, cur_addr, a);
   endtask

   task automatic do_fill(input logic [4:0] a, input logic [7:0] d, input bit disturb);
      int nd, nb; bit di;
      logic [4:0] ea;
      logic [7:0] ed;
      run_op(M_FILL, a, d, disturb, nd, nb, di);
      for (int i = 0; i < DEPTH; i++) begin
         ea = a + 5'(i);
         ed = d + 8'(i);
         mem_m[ea] = ed;
      end
      check("fill_cycles", nb, DEPTH);
      check("fill_done", nd, 1);
      check("fill_done_idle", di, 1'b1);
      check("fill_last_addr", cur_addr, ea);
      check("fill_last_q", q, ed);
      check("fill_flag", wr_flag, 1'b1);
   endtask

   task automatic read_all(input string tag);
      for (int i = 0; i < DEPTH; i++) do_read(tag, 5'(i));
   endtask

   initial begin
      logic [7:0] prev_q;
      logic [4:0] prev_a;
      logic [7:0] q_seen[$];
      logic [4:0] a_seen[$];
      int         t_seen[$];
      int         nd;
      bit         found;
      logic [4:0] ra;
      logic [7:0] rd;

      resetn = 1'b0; go = 1'b0; mode = M_READ; addr_in = '0; data_in = '0;

      // Reset state.
      repeat (3) @(negedge clock);
      check("rst_cur_addr", cur_addr, 0);
      check("rst_q", q, 0);
      check("rst_wr_flag", wr_flag, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      resetn = 1'b1;
      repeat (2) @(negedge clock);

      // WRITE then READ back.
      do_write(5'h1A, 8'hC3);
      do_read("rd1a", 5'h1A);

      // FILL with address and data wrap.
      do_fill(5'h1E, 8'hFE, 1'b0);
      check("fill_m1e", mem_m[5'h1E], 8'hFE);
      do_read("rd1e", 5'h1E);
      do_read("rd1f", 5'h1F);
      do_read("rd00", 5'h00);
      do_read("rd1d", 5'h1D);

      // SCAN from 0x1F: three q updates with address wrap, spaced DWELL+2.
      prev_q = q; prev_a = cur_addr;
      @(negedge clock);
      mode = M_SCAN; addr_in = 5'h1F; go = 1'b1;
      for (int c = 0; c < 200; c++) begin
         @(negedge clock);
         if (c == 2) go = 1'b0;
         if (cur_addr !== prev_a) begin
            a_seen.push_back(cur_addr);
            prev_a = cur_addr;
         end
         if (q !== prev_q) begin
            q_seen.push_back(q);
            t_seen.push_back(c);
            prev_q = q;
         end
         if (q_seen.size() == 3) break;
      end
      check("scan_qcount", q_seen.size(), 3);
      if (q_seen.size() == 3 && a_seen.size() >= 3) begin
         check("scan_q0", q_seen[0], mem_m[5'h1F]);
         check("scan_q1", q_seen[1], mem_m[5'h00]);
         check("scan_q2", q_seen[2], mem_m[5'h01]);
         check("scan_a0", a_seen[0], 5'h1F);
         check("scan_a1", a_seen[1], 5'h00);
         check("scan_a2", a_seen[2], 5'h01);
         check("scan_period1", t_seen[1] - t_seen[0], DWELL + 2);
         check("scan_period2", t_seen[2] - t_seen[1], DWELL + 2);
         check("scan_busy", busy, 1'b1);
      end

      // Second press stops the scan right after an update: address held.
      go = 1'b1;
      nd = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clock);
         if (c == 2) go = 1'b0;
         if (done) begin
            nd++;
            check("stop_busy", busy, 1'b0);
            check("stop_addr", cur_addr, 5'h01);
            check("stop_q", q, mem_m[5'h01]);
         end
      end
      check("stop_done_count", nd, 1);
      check("stop_addr_held", cur_addr, 5'h01);
      check("stop_idle", busy, 1'b0);

      // Leaving SCAN mode on the switches also stops the scan.
      prev_q = q;
      @(negedge clock);
      mode = M_SCAN; addr_in = 5'h05; go = 1'b1;
      found = 1'b0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clock);
         if (c == 2) go = 1'b0;
         if (q !== prev_q) begin
            found = 1'b1;
            break;
         end
      end
      check("mstop_update", found, 1'b1);
      mode = M_READ;
      nd = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clock);
         if (done) nd++;
      end
      go = 1'b0;
      check("mstop_done", nd, 1);
      check("mstop_busy", busy, 1'b0);
      check("mstop_addr", cur_addr, 5'h05);
      check("mstop_q", q, mem_m[5'h05]);
      repeat (3) @(negedge clock);

      // Randomized reads and writes against the model.
      for (int n = 0; n < 24; n++) begin
         ra = 5'($urandom_range(0, DEPTH - 1));
         rd = 8'($urandom);
         if ($urandom_range(0, 1) == 1) do_write(ra, rd);
         else do_read("rnd", ra);
      end

      // Busy lockout: extra press and switch changes during a FILL.
      do_fill(5'($urandom), 8'($urandom), 1'b1);
      read_all("lock");

      // Reset in the middle of a FILL, when five words have been written.
      @(negedge clock);
      mode = M_FILL; addr_in = 5'h03; data_in = 8'h40; go = 1'b1;
      found = 1'b0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clock);
         if (c == 2) go = 1'b0;
         if (busy && cur_addr == 5'h07 && q == 8'h44) begin
            found = 1'b1;
            break;
         end
      end
      go = 1'b0;
      check("rstfill_reach", found, 1'b1);
      #2 resetn = 1'b0;
      #1;
      check("rstfill_addr", cur_addr, 0);
      check("rstfill_q", q, 0);
      check("rstfill_flag", wr_flag, 0);
      check("rstfill_busy", busy, 0);
      check("rstfill_done", done, 0);
      for (int i = 0; i < 5; i++) mem_m[5'h03 + 5'(i)] = 8'h40 + 8'(i);
      repeat (2) @(negedge clock);
      resetn = 1'b1;
      repeat (2) @(negedge clock);
      read_all("rstf");

      // Synchroniser: a glitch between edges produces at most one start.
      @(negedge clock);
      mode = M_READ; addr_in = 5'h02;
      #1 go = 1'b1;
      #3 go = 1'b0;
      nd = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clock);
         if (done) nd++;
      end
      check("glitch_le1", (nd <= 1), 1'b1);

      // Clean rise: FSM acts at edge 2; a long level gives exactly one start.
      @(negedge clock);
      mode = M_READ; addr_in = 5'h09; go = 1'b1;
      nd = 0;
      for (int c = 0; c < 1000; c++) begin
         @(negedge clock);
         if (c == 0) check("edge0_busy", busy, 1'b0);
         if (c == 1) check("edge1_busy", busy, 1'b0);
         if (c == 2) check("edge2_busy", busy, 1'b1);
         if (done) nd++;
      end
      go = 1'b0;
      repeat (10) @(negedge clock);
      check("level_done", nd, 1);
      check("level_q", q, mem_m[5'h09]);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
